// File: rtl/echo_delay.sv
// Feedback echo on a RAM circular buffer with runtime delay, feedback gain and wet-mix gain.
// Optional `define ECHO_DELAY_BYPASS_EN adds a bypass input that passes the dry sample through.
module echo_delay #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 10,
    parameter int GAIN_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  sample_in,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [GAIN_W-1:0] fb_gain,
    input  logic [GAIN_W-1:0] mix_gain,
`ifdef ECHO_DELAY_BYPASS_EN
    input  logic              bypass,
`endif
    output logic [WIDTH-1:0]  sample_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int PW    = WIDTH + GAIN_W + 1;
    localparam logic signed [PW-1:0] MAX_V = PW'((2**(WIDTH-1)) - 1);
    localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [WIDTH-1:0]    rd_data_reg;
    logic [WIDTH-1:0]    in_reg;
    logic [ADDR_W-1:0]   dly_reg;
    logic [GAIN_W-1:0]   fbg_reg;
    logic [GAIN_W-1:0]   mixg_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   fill_reg;
    logic [WIDTH-1:0]    wr_data_reg;
    logic [WIDTH-1:0]    sample_out_reg;
    logic                overrun_reg;
    logic                accept;
    logic                mem_we;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic                echo_on;
    logic signed [PW-1:0] echo_x, in_x, fbg_x, mixg_x;
    logic signed [PW-1:0] fb_term, mix_term, fb_sum, mix_sum;
    logic [WIDTH-1:0]    out_calc;
`ifdef ECHO_DELAY_BYPASS_EN
    logic                bypass_reg;
`endif

    // Intermediate sums are wider than WIDTH+1 but the gain is < 1, so the clamped result is identical.
    function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > MAX_V)
            return MAX_V[WIDTH-1:0];
        else if (v < MIN_V)
            return MIN_V[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sample_valid) state_next = READ;
            READ:    state_next = CALC;
            CALC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == WRITE);
        mem_we    = (state_reg == WRITE);
        rd_en     = (state_reg == READ);
        accept    = (state_reg == IDLE) && sample_valid;
    end

    assign rd_addr = wr_ptr_reg - dly_reg;

    // Echo is suppressed until the tap points at a sample written since reset.
    always_comb begin
        echo_on  = (dly_reg != '0) && (dly_reg <= fill_reg);
        echo_x   = echo_on ? {{(PW-WIDTH){rd_data_reg[WIDTH-1]}}, rd_data_reg} : '0;
        in_x     = {{(PW-WIDTH){in_reg[WIDTH-1]}}, in_reg};
        fbg_x    = {{(PW-GAIN_W){1'b0}}, fbg_reg};
        mixg_x   = {{(PW-GAIN_W){1'b0}}, mixg_reg};
        fb_term  = (echo_x * fbg_x) >>> GAIN_W;
        mix_term = (echo_x * mixg_x) >>> GAIN_W;
        fb_sum   = in_x + fb_term;
        mix_sum  = in_x + mix_term;
`ifdef ECHO_DELAY_BYPASS_EN
        out_calc = bypass_reg ? in_reg : sat(mix_sum);
`else
        out_calc = sat(mix_sum);
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr_reg] <= wr_data_reg;
        if (rd_en)
            rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_reg         <= '0;
            dly_reg        <= '0;
            fbg_reg        <= '0;
            mixg_reg       <= '0;
            wr_ptr_reg     <= '0;
            fill_reg       <= '0;
            wr_data_reg    <= '0;
            sample_out_reg <= '0;
            overrun_reg    <= 1'b0;
`ifdef ECHO_DELAY_BYPASS_EN
            bypass_reg     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                in_reg   <= sample_in;
                dly_reg  <= delay_len;
                fbg_reg  <= fb_gain;
                mixg_reg <= mix_gain;
`ifdef ECHO_DELAY_BYPASS_EN
                bypass_reg <= bypass;
`endif
            end
            if (sample_valid && (state_reg != IDLE))
                overrun_reg <= 1'b1;
            if (state_reg == CALC) begin
                sample_out_reg <= out_calc;
                wr_data_reg    <= sat(fb_sum);
            end
            if (state_reg == WRITE) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                if (fill_reg != '1)
                    fill_reg <= fill_reg + ADDR_W'(1);
            end
        end
    end

    assign sample_out = sample_out_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_echo_delay.sv
// Randomised and directed bench for echo_delay against a sample-history reference model.
// Uses a small buffer (ADDR_W=3) so pointer wrap and fill saturation occur quickly.
module tb_echo_delay;

    localparam int WIDTH  = 12;
    localparam int ADDR_W = 3;
    localparam int GAIN_W = 4;
    localparam int DEPTH  = 2**ADDR_W;
    localparam int MAXS   = 2**(WIDTH-1) - 1;
    localparam int MINS   = -(2**(WIDTH-1));

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [WIDTH-1:0]  sample_in = '0;
    logic              sample_valid = 1'b0;
    logic [ADDR_W-1:0] delay_len = '0;
    logic [GAIN_W-1:0] fb_gain = '0;
    logic [GAIN_W-1:0] mix_gain = '0;
`ifdef ECHO_DELAY_BYPASS_EN
    logic              bypass = 1'b0;
`endif
    logic [WIDTH-1:0]  sample_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    int vectors = 0;
    int miscompares = 0;
    int hist[$];

    echo_delay #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .delay_len(delay_len),
        .fb_gain(fb_gain),
        .mix_gain(mix_gain),
`ifdef ECHO_DELAY_BYPASS_EN
        .bypass(bypass),
`endif
        .sample_out(sample_out),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic int floor16(input int p);
        if (p >= 0) return p / 16;
        return -((-p + 15) / 16);
    endfunction

    function automatic int clamp(input int v);
        if (v > MAXS) return MAXS;
        if (v < MINS) return MINS;
        return v;
    endfunction

    // Output for one accepted sample; the full written history stands in for the circular buffer.
    function automatic int model_step(input int din, input int d, input int fb, input int mix);
        int n    = hist.size();
        int fill = (n > DEPTH-1) ? DEPTH-1 : n;
        int echo = 0;
        if (d != 0 && d <= fill) echo = hist[n-d];
        hist.push_back(clamp(din + floor16(echo * fb)));
        return clamp(din + floor16(echo * mix));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        hist.delete();
    endtask

    // Strobe one sample, scramble the controls after acceptance, capture out_valid over the next 3 cycles.
    task automatic apply(input int din, input int d, input int fb, input int mix,
                         output int got, output int pat);
        @(negedge clk);
        sample_in    = WIDTH'(din);
        delay_len    = ADDR_W'(d);
        fb_gain      = GAIN_W'(fb);
        mix_gain     = GAIN_W'(mix);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in    = WIDTH'($urandom);
        delay_len    = ADDR_W'($urandom);
        fb_gain      = GAIN_W'($urandom);
        mix_gain     = GAIN_W'($urandom);
        pat = int'(out_valid) * 4;
        @(negedge clk);
        pat = pat + int'(out_valid) * 2;
        @(negedge clk);
        pat = pat + int'(out_valid);
        got = int'($signed(sample_out));
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({sample_out, out_valid, busy, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: out=%0d valid=%0b busy=%0b ovr=%0b, required all 0",
                     sample_out, out_valid, busy, overrun);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if ({sample_out, out_valid, busy, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_release: out=%0d valid=%0b busy=%0b ovr=%0b, required all 0",
                     sample_out, out_valid, busy, overrun);
        end
    endtask

    task automatic test_fill();
        int got, pat, req, exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp = model_step(100, 4, 0, 8);
            apply(100, 4, 0, 8, got, pat);
            req = (i < 4) ? 100 : 150;
            vectors++;
            if (got !== req || pat !== 1) begin
                miscompares++;
                $display("FAIL fill[%0d]: out=%0d pat=%0d, required out=%0d pat=1", i, got, pat, req);
            end
            $display("fill[%0d] in=100 out=%0d model=%0d", i, got, exp);
        end
    endtask

    task automatic test_impulse();
        int got, pat, exp, din;
        int req[10] = '{1000, 0, 0, 500, 0, 0, 250, 0, 0, 125};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            din = (i == 0) ? 1000 : 0;
            exp = model_step(din, 3, 8, 8);
            apply(din, 3, 8, 8, got, pat);
            vectors++;
            if (got !== req[i] || pat !== 1) begin
                miscompares++;
                $display("FAIL impulse[%0d]: out=%0d pat=%0d, required out=%0d pat=1", i, got, pat, req[i]);
            end
            $display("impulse[%0d] in=%0d out=%0d model=%0d", i, din, got, exp);
        end
    endtask

    task automatic test_saturation();
        int got, pat, exp, din, lim;
        for (int s = 0; s < 2; s++) begin
            din = (s == 0) ? 2000 : -2000;
            lim = (s == 0) ? MAXS : MINS;
            do_reset();
            for (int i = 0; i < 10; i++) begin
                exp = model_step(din, 1, 15, 15);
                apply(din, 1, 15, 15, got, pat);
                vectors++;
                if (got !== exp || pat !== 1 || (i > 0 && got !== lim)) begin
                    miscompares++;
                    $display("FAIL sat[%0d][%0d]: out=%0d pat=%0d, required out=%0d (limit %0d) pat=1",
                             s, i, got, pat, exp, lim);
                end
                $display("sat[%0d][%0d] in=%0d out=%0d", s, i, din, got);
            end
        end
    endtask

    task automatic test_overrun();
        int got, pat, exp, pulses;
        do_reset();
        exp = model_step(300, 2, 8, 8);
        @(negedge clk);
        sample_in = WIDTH'(300); delay_len = 2; fb_gain = 8; mix_gain = 8;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        pulses = int'(out_valid);
        @(negedge clk);
        pulses += int'(out_valid);
        sample_in = WIDTH'(999);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        got = int'($signed(sample_out));
        vectors++;
        if (out_valid !== 1'b1 || got !== exp || overrun !== 1'b1 || pulses !== 0) begin
            miscompares++;
            $display("FAIL overrun_c3: valid=%0b out=%0d ovr=%0b early=%0d, required valid=1 out=%0d ovr=1 early=0",
                     out_valid, got, overrun, pulses, exp);
        end
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pulses += int'(out_valid);
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL overrun_dropped: extra out_valid pulses=%0d, required 0", pulses);
        end
        exp = model_step(40, 1, 0, 8);
        apply(40, 1, 0, 8, got, pat);
        vectors++;
        if (got !== exp || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: out=%0d ovr=%0b, required out=%0d ovr=1", got, overrun, exp);
        end
        do_reset();
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: ovr=%0b, required 0", overrun);
        end
        $display("overrun sequence done, post-reset ovr=%0b", overrun);
    endtask

    task automatic test_wrap();
        int got, pat, exp, req;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            exp = model_step(k, 7, 0, 8);
            apply(k, 7, 0, 8, got, pat);
            req = (k > 7) ? k + (k - 7) / 2 : k;
            vectors++;
            if (got !== req || pat !== 1) begin
                miscompares++;
                $display("FAIL wrap[%0d]: out=%0d pat=%0d, required out=%0d pat=1", k, got, pat, req);
            end
            $display("wrap[%0d] out=%0d model=%0d", k, got, exp);
        end
    endtask

    task automatic test_reset_midop();
        int got, pat, exp, pulses;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            exp = model_step(600, 1, 8, 8);
            apply(600, 1, 8, 8, got, pat);
        end
        @(negedge clk);
        sample_in = WIDTH'(500); delay_len = 1; fb_gain = 8; mix_gain = 8;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (sample_out !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset: out=%0d valid=%0b busy=%0b, required 0 0 0", sample_out, out_valid, busy);
        end
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pulses += int'(out_valid);
        end
        reset_n = 1'b1;
        hist.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pulses += int'(out_valid);
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL midop_no_valid: pulses=%0d, required 0", pulses);
        end
        exp = model_step(700, 1, 8, 8);
        apply(700, 1, 8, 8, got, pat);
        vectors++;
        if (got !== 700 || got !== exp || pat !== 1) begin
            miscompares++;
            $display("FAIL midop_dry: out=%0d pat=%0d, required out=700 pat=1", got, pat);
        end
        $display("midop after reset out=%0d", got);
    endtask

    task automatic test_random();
        int got, pat, exp, din, d, fb, mix;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            din = int'($urandom_range(4095)) - 2048;
            d   = int'($urandom_range(DEPTH-1));
            fb  = int'($urandom_range(15));
            mix = int'($urandom_range(15));
            exp = model_step(din, d, fb, mix);
            apply(din, d, fb, mix, got, pat);
            vectors++;
            if (got !== exp || pat !== 1) begin
                miscompares++;
                $display("FAIL random[%0d]: in=%0d d=%0d fb=%0d mix=%0d out=%0d pat=%0d, required out=%0d pat=1",
                         i, din, d, fb, mix, got, pat, exp);
            end
            $display("random[%0d] in=%0d d=%0d fb=%0d mix=%0d out=%0d", i, din, d, fb, mix, got);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL random_overrun: ovr=%0b, required 0", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_impulse();
        test_saturation();
        test_overrun();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/echo_delay.md
Name: echo_delay

Overview:
- Parametrised feedback echo for the pedal's effect chain.
- Next generation of the fixed shift-register delay. It replaces the flop chain with a RAM circular buffer whose delay is selectable at runtime, and adds feedback (repeating echoes) plus wet-mix gain.
- Sits between the ADC sample stage and the DAC output stage, clocked on the system clock and advanced by the per-sample strobe.

Parameters:
- WIDTH, 12, sample width in bits; samples are two's complement signed.
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples (default 1024).
- GAIN_W, 4, gain width; gain g means g / 2**GAIN_W (0 to 15/16).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- sample_in  input  WIDTH  new dry sample.
- sample_valid  input  1  one-cycle strobe: sample_in is valid.
- delay_len  input  ADDR_W  echo delay in samples; 0 means no echo.
- fb_gain  input  GAIN_W  feedback gain written back into the buffer.
- mix_gain  input  GAIN_W  wet level added to the output.
- sample_out  output  WIDTH  dry plus wet result, held until the next result.
- out_valid  output  1  one-cycle strobe: sample_out is updated.
- busy  output  1  high while the FSM is not in IDLE.
- overrun  output  1  sticky; set when a strobe is dropped, cleared only by reset.

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: sample_out=0, out_valid=0, busy=0, overrun=0; wr_ptr=0; fill=0; FSM in IDLE.
- Buffer RAM contents are not reset.
- FSM states: IDLE -> READ -> CALC -> WRITE -> IDLE.
- IDLE: on sample_valid, latch sample_in, delay_len, fb_gain and mix_gain; go to READ.
- READ: rd_addr = (wr_ptr - delay_len) mod DEPTH; issue the synchronous RAM read.
- CALC:
  - echo = RAM data if (delay_len != 0 and delay_len <= fill), else 0.
  - Uninitialised RAM is never heard.
- WRITE:
  - mem[wr_ptr] = sat(in + (echo*fb_gain >>> GAIN_W)).
  - sample_out = sat(in + (echo*mix_gain >>> GAIN_W)).
  - out_valid=1 for this cycle only.
  - wr_ptr increments and wraps DEPTH-1 -> 0.
  - fill increments and saturates at DEPTH-1.
- Latency: sample_valid at cycle N gives out_valid at cycle N+3. Maximum accepted strobe rate is one per 4 cycles.
- Arithmetic:
  - Products are formed at WIDTH+GAIN_W+1 bits and arithmetic-shifted right (floor toward minus infinity).
  - Sums are formed at WIDTH+1 bits, then saturated to [-2**(WIDTH-1), 2**(WIDTH-1)-1].
  - No wrap-around, ever.
- sample_valid while busy=1: the sample is ignored, overrun is set, and the in-flight operation completes unaffected.
- delay_len and gain changes mid-operation have no effect until the next accepted sample.
- delay_len=0: output equals the dry sample, and the dry sample is still written to the buffer.
- fb_gain=0 gives a single echo; the maximum fb_gain (15/16) decays and never grows without bound.
- Reset asserted mid-operation: all state returns to reset values immediately; no out_valid pulse is issued for the aborted sample.

Optional Feature:
- Macro: ECHO_DELAY_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - When bypass=1 at acceptance: sample_out = sample_in unmodified, with the same 3-cycle latency and out_valid timing.
  - The buffer is still written with sat(in + fb echo), so trails resume naturally when bypass returns to 0.
- When undefined: no bypass port; the effect is always active.

Test Plan:
- Reset and fill: after reset, delay_len=4, mix_gain=8, fb_gain=0; strobe in=100 every 4 cycles -> first 4 outputs = 100; from the 5th sample onward output = 100 + 50 = 150.
- Impulse echo: in=1000 then zeros, delay_len=3, mix=8, fb=8 -> outputs 1000,0,0,500,0,0,250,0,0,125 (floor halving).
- Saturation: in=2000, delay_len=1, mix=15, fb=15, constant input -> output clips at 2047 and never wraps negative. Repeat with in=-2000 -> output clips at -2048.
- Timing and overrun: strobe at cycle 0 and again at cycle 2 -> out_valid only at cycle 3; overrun=1 and stays 1 until reset_n pulse.
- Wrap-around: ADDR_W=3, delay_len=7, ramp inputs 1..20 with mix=16/16 not allowed, so mix=8 -> output at sample k = k + floor((k-7)/2) for k>7, correct across pointer wrap.
- Reset mid-op: assert reset_n=0 in CALC -> no out_valid; sample_out=0; next sample after release sees fill=0, giving dry-only output.
